// File: rtl/obuf_pkg.sv
// Shared definitions for the OBUF store/load schedulers: state encoding,
// default widths and the outstanding-counter width helper.
package obuf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam int DEF_TAG_W           = 1;
  localparam int DEF_ADDR_W          = 42;
  localparam int DEF_ROW_CNT_W       = 16;
  localparam int DEF_LEN_W           = 8;
  localparam int DEF_MAX_OUTSTANDING = 8;

  // One extra bit so the counter can hold MAX_OUTSTANDING itself.
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out) + 1;
  endfunction

endpackage

// File: rtl/obuf_stmem_sched_if.sv
// DDR write request / response channel between the OBUF store scheduler
// (master) and the memory controller (slave).
interface obuf_stmem_sched_if #(
  parameter int TAG_W  = 1,
  parameter int ADDR_W = 42,
  parameter int LEN_W  = 8
) ();

  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [LEN_W-1:0]  wr_req_len;
  logic [TAG_W-1:0]  wr_req_tag;
  logic              wr_resp_valid;

  modport master (
    output wr_req_valid, wr_req_addr, wr_req_len, wr_req_tag,
    input  wr_req_ready, wr_resp_valid
  );

  modport slave (
    input  wr_req_valid, wr_req_addr, wr_req_len, wr_req_tag,
    output wr_req_ready, wr_resp_valid
  );

endinterface

// File: rtl/obuf_outstanding_cnt.sv
// Up/down counter of requests awaiting a response, with a limit flag and a
// sticky underflow flag; shared by the OBUF store and load schedulers.
module obuf_outstanding_cnt
  import obuf_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  localparam int CNT_W          = cnt_w(MAX_OUTSTANDING)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic dec_i,
  output logic at_limit_o,
  output logic empty_o,
  output logic underflow_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;
  logic             dec_ok;

  // A response with nothing outstanding is dropped and only flagged.
  assign dec_ok = dec_i && (count_q != '0);

  always_comb begin
    count_d     = count_q;
    underflow_d = underflow_q | (dec_i && (count_q == '0));
    case ({inc_i, dec_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  assign at_limit_o  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty_o     = (count_q == '0);
  assign underflow_o = underflow_q;

endmodule

// File: rtl/obuf_stmem_sched.sv
// OBUF store-side scheduler: drains each ready tag as one DDR write per row and
// releases the tag once all responses return. Optional perf counters: OBUF_STMEM_PERF_EN.
module obuf_stmem_sched
  import obuf_pkg::*;
#(
  parameter int TAG_W           = DEF_TAG_W,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int ROW_CNT_W       = DEF_ROW_CNT_W,
  parameter int LEN_W           = DEF_LEN_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic [ADDR_W-1:0]    cfg_base_addr,
  input  logic [ADDR_W-1:0]    cfg_row_stride,
  input  logic [ADDR_W-1:0]    cfg_tile_stride,
  input  logic [ROW_CNT_W-1:0] cfg_num_rows,
  input  logic [LEN_W-1:0]     cfg_burst_len,
  input  logic                 stmem_tag_ready,
  input  logic [TAG_W-1:0]     stmem_tag,
  input  logic                 stmem_ddr_pe_sw,
  output logic                 stmem_tag_done,
  obuf_stmem_sched_if.master   wr,
  output logic                 busy,
  output logic                 err_resp_underflow
`ifdef OBUF_STMEM_PERF_EN
  ,
  output logic [31:0]          perf_busy_cycles,
  output logic [31:0]          perf_stall_cycles
`endif
);

  sched_state_e         state_q, state_d;
  logic [ADDR_W-1:0]    tile_base_q, tile_base_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ROW_CNT_W-1:0] row_idx_q, row_idx_d;
  logic [ROW_CNT_W-1:0] num_rows_q, num_rows_d;
  logic [LEN_W-1:0]     burst_q, burst_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 ddr_q, ddr_d;

  logic req_valid, accept, at_limit, cnt_empty;

  assign req_valid = (state_q == ISSUE) && !at_limit;
  assign accept    = req_valid && wr.wr_req_ready;

  obuf_outstanding_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_outstanding (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (accept),
    .dec_i      (wr.wr_resp_valid),
    .at_limit_o (at_limit),
    .empty_o    (cnt_empty),
    .underflow_o(err_resp_underflow)
  );

  always_comb begin
    state_d     = state_q;
    tile_base_d = tile_base_q;
    addr_d      = addr_q;
    row_idx_d   = row_idx_q;
    num_rows_d  = num_rows_q;
    burst_d     = burst_q;
    tag_d       = tag_q;
    ddr_d       = ddr_q;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          tile_base_d = cfg_base_addr;
        end else if (stmem_tag_ready) begin
          tag_d      = stmem_tag;
          ddr_d      = stmem_ddr_pe_sw;
          num_rows_d = cfg_num_rows;
          burst_d    = cfg_burst_len;
          addr_d     = tile_base_q;
          row_idx_d  = '0;
          state_d    = (!stmem_ddr_pe_sw || cfg_num_rows == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        // Row address advances by the stride on every accept instead of a multiply.
        if (accept) begin
          addr_d    = addr_q + cfg_row_stride;
          row_idx_d = row_idx_q + ROW_CNT_W'(1);
          if (row_idx_q == num_rows_q - ROW_CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_empty) state_d = DONE;
      end
      DONE: begin
        if (ddr_q) tile_base_d = tile_base_q + cfg_tile_stride;
        row_idx_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tile_base_q <= '0;
      addr_q      <= '0;
      row_idx_q   <= '0;
      num_rows_q  <= '0;
      burst_q     <= '0;
      tag_q       <= '0;
      ddr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_base_q <= tile_base_d;
      addr_q      <= addr_d;
      row_idx_q   <= row_idx_d;
      num_rows_q  <= num_rows_d;
      burst_q     <= burst_d;
      tag_q       <= tag_d;
      ddr_q       <= ddr_d;
    end
  end

  assign wr.wr_req_valid = req_valid;
  assign wr.wr_req_addr  = addr_q;
  assign wr.wr_req_len   = burst_q;
  assign wr.wr_req_tag   = tag_q;
  assign stmem_tag_done  = (state_q == DONE);
  assign busy            = (state_q != IDLE);

`ifdef OBUF_STMEM_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (cfg_start) begin
      perf_busy_d  = '0;
      perf_stall_d = '0;
    end else begin
      if (busy && !(&perf_busy_q)) perf_busy_d = perf_busy_q + 32'd1;
      if (req_valid && !wr.wr_req_ready && !(&perf_stall_q)) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: doc/obuf_stmem_sched.md
Name: obuf_stmem_sched

Overview:
- Downstream consumer of the OBUF tag synchroniser's store side. Waits for a tag to reach the store phase, then issues one DDR write request per output row with the right address.
- Tracks outstanding write responses and pulses stmem_tag_done once the tile has fully drained, which frees the tag for reuse.
- Tiles that stay on-chip (stmem_ddr_pe_sw=0) are retired without any DDR traffic.

Parameters:
- TAG_W, 1, width of the buffer tag
- ADDR_W, 42, DDR byte-address width
- ROW_CNT_W, 16, width of the row counters
- LEN_W, 8, width of the burst-length field
- MAX_OUTSTANDING, 8, maximum write requests awaiting a response (power of 2, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cfg_start  in  1  pulse: load cfg_base_addr and clear the tile counter
- cfg_base_addr  in  ADDR_W  DDR address of tile 0
- cfg_row_stride  in  ADDR_W  byte stride between rows
- cfg_tile_stride  in  ADDR_W  byte stride between consecutive tiles
- cfg_num_rows  in  ROW_CNT_W  rows per tile
- cfg_burst_len  in  LEN_W  beats per row write
- stmem_tag_ready  in  1  current store tag is ready to be drained
- stmem_tag  in  TAG_W  current store tag
- stmem_ddr_pe_sw  in  1  1 = write the tile to DDR; 0 = retire it without traffic
- stmem_tag_done  out  1  one-cycle pulse: tag released
- wr_req_valid  out  1  write request valid
- wr_req_ready  in  1  write request accepted
- wr_req_addr  out  ADDR_W  row address
- wr_req_len  out  LEN_W  burst length
- wr_req_tag  out  TAG_W  OBUF tag to read from
- wr_resp_valid  in  1  one write response
- busy  out  1  state is not IDLE
- err_resp_underflow  out  1  sticky: a response arrived with zero outstanding

Behaviour:
- Reset (asynchronous, active-high) clears:
  - state to IDLE and all outputs to 0;
  - tile_base to 0, row counter to 0, outstanding count to 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - cfg_start loads tile_base from cfg_base_addr; this takes priority and is ignored outside IDLE.
  - Otherwise, if stmem_tag_ready=1, latch stmem_tag, stmem_ddr_pe_sw, cfg_num_rows and cfg_burst_len.
  - Next state: DONE if ddr_pe_sw=0 or num_rows=0; else ISSUE.
- ISSUE:
  - wr_req_valid=1 whenever outstanding < MAX_OUTSTANDING.
  - wr_req_addr = tile_base + row_idx*cfg_row_stride, computed incrementally by adding the stride on each accept; truncate to ADDR_W, wrap allowed.
  - wr_req_len is the latched burst length; wr_req_tag is the latched tag.
  - An accept is valid&&ready: it increments row_idx and outstanding.
  - Once the last row is accepted, go to DRAIN.
  - Valid, addr, len and tag stay stable until accepted.
- DRAIN: wait for outstanding==0, then go to DONE.
- DONE:
  - stmem_tag_done=1 for exactly one cycle.
  - tile_base += cfg_tile_stride, applied only for DDR tiles.
  - row_idx cleared; return to IDLE.
  - The minimum gap between consecutive stmem_tag_done pulses is 2 cycles.
- Outstanding counter:
  - width clog2(MAX_OUTSTANDING)+1;
  - +1 on accept, −1 on wr_resp_valid;
  - simultaneous accept and response leaves it unchanged;
  - a response at 0 is ignored and sets err_resp_underflow, which clears only on reset.
- Latency: DDR tile, stmem_tag_ready seen in IDLE → first wr_req_valid 1 cycle later. Bypass tile → stmem_tag_done 1 cycle later.
- wr_resp_valid is accepted in every state, including IDLE (late responses still decrement).
- stmem_tag_ready dropping mid-tile is ignored, because the tag is latched.
- With outstanding at MAX_OUTSTANDING, valid is held low until a response arrives.

Optional Feature:
- Macro: OBUF_STMEM_PERF_EN.
- Defined:
  - adds outputs perf_busy_cycles[31:0] (counts cycles with busy=1) and perf_stall_cycles[31:0] (counts cycles with wr_req_valid&&!wr_req_ready);
  - both saturate at all-ones and clear on reset or cfg_start.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package obuf_pkg:
  - state encoding: IDLE=0, ISSUE=1, DRAIN=2, DONE=3;
  - default widths.
- One natural sub-module, obuf_outstanding_cnt: up/down counter with limit flag and underflow flag, reusable by the load side.

Test Plan:
- Basic drain. Stimulus: cfg_base=0x1000, row_stride=0x40, num_rows=4, burst=4, ready always 1, response 3 cycles after each accept. Response: 4 requests at addr 0x1000/0x1040/0x1080/0x10C0, tag latched; stmem_tag_done pulses once, after the 4th response.
- Bypass tile. Stimulus: stmem_ddr_pe_sw=0, num_rows=4. Response: no wr_req_valid; stmem_tag_done 1 cycle after stmem_tag_ready; tile_base unchanged.
- Backpressure. Stimulus: MAX_OUTSTANDING=8, num_rows=20, responses withheld. Response: exactly 8 accepts, then valid low; 3 responses released → 3 further accepts; done only once outstanding returns to 0.
- Tile advance. Stimulus: cfg_tile_stride=0x800, two back-to-back tiles. Response: second tile's first addr is 0x1800; done pulses at least 2 cycles apart.
- Boundaries:
  - num_rows=0 → done with no requests;
  - an unexpected response in IDLE → err_resp_underflow=1;
  - accept and response in the same cycle → outstanding unchanged.
- Reset mid-ISSUE. Stimulus: assert reset asynchronously between clock edges after 2 accepts. Response: all outputs 0 immediately, state IDLE, counters 0; a fresh tile then drains normally.
